// File: rtl/axil_rr_arbiter_2m.sv
// Two-master to one-slave AXI4-Lite arbiter. It grants one complete read or write
// transaction at a time and alternates priority between the masters round-robin.
module axil_rr_arbiter_2m #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   s0_AWADDR,
  input  logic                s0_AWVALID,
  output logic                s0_AWREADY,
  input  logic [DATA_W-1:0]   s0_WDATA,
  input  logic [DATA_W/8-1:0] s0_WSTRB,
  input  logic                s0_WVALID,
  output logic                s0_WREADY,
  output logic [1:0]          s0_BRESP,
  output logic                s0_BVALID,
  input  logic                s0_BREADY,
  input  logic [ADDR_W-1:0]   s0_ARADDR,
  input  logic                s0_ARVALID,
  output logic                s0_ARREADY,
  output logic [DATA_W-1:0]   s0_RDATA,
  output logic [1:0]          s0_RRESP,
  output logic                s0_RVALID,
  input  logic                s0_RREADY,
  input  logic [ADDR_W-1:0]   s1_AWADDR,
  input  logic                s1_AWVALID,
  output logic                s1_AWREADY,
  input  logic [DATA_W-1:0]   s1_WDATA,
  input  logic [DATA_W/8-1:0] s1_WSTRB,
  input  logic                s1_WVALID,
  output logic                s1_WREADY,
  output logic [1:0]          s1_BRESP,
  output logic                s1_BVALID,
  input  logic                s1_BREADY,
  input  logic [ADDR_W-1:0]   s1_ARADDR,
  input  logic                s1_ARVALID,
  output logic                s1_ARREADY,
  output logic [DATA_W-1:0]   s1_RDATA,
  output logic [1:0]          s1_RRESP,
  output logic                s1_RVALID,
  input  logic                s1_RREADY,
  output logic [ADDR_W-1:0]   m0_AWADDR,
  output logic                m0_AWVALID,
  input  logic                m0_AWREADY,
  output logic [DATA_W-1:0]   m0_WDATA,
  output logic [DATA_W/8-1:0] m0_WSTRB,
  output logic                m0_WVALID,
  input  logic                m0_WREADY,
  input  logic [1:0]          m0_BRESP,
  input  logic                m0_BVALID,
  output logic                m0_BREADY,
  output logic [ADDR_W-1:0]   m0_ARADDR,
  output logic                m0_ARVALID,
  input  logic                m0_ARREADY,
  input  logic [DATA_W-1:0]   m0_RDATA,
  input  logic [1:0]          m0_RRESP,
  input  logic                m0_RVALID,
  output logic                m0_RREADY,
  output logic [1:0]          gnt,
  output logic                busy
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_ADDR = 3'd1;
  localparam logic [2:0] WR_RESP = 3'd2;
  localparam logic [2:0] RD_ADDR = 3'd3;
  localparam logic [2:0] RD_DATA = 3'd4;

  logic [2:0] state, state_nxt;
  logic [1:0] gnt_nxt;
  logic       last, last_nxt;
  logic       aw_done, aw_done_nxt;
  logic       w_done, w_done_nxt;
  logic       sel;
  logic       aw_rdy, w_rdy;
  logic       req0, req1, pick1;
  logic       aw_hs, w_hs;

  // gnt is one-hot, so bit 1 alone selects the granted master
  assign sel = gnt[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= 2'b00;
      last    <= 1'b1;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      gnt     <= gnt_nxt;
      last    <= last_nxt;
      aw_done <= aw_done_nxt;
      w_done  <= w_done_nxt;
      busy    <= (state_nxt != IDLE);
    end
  end

  // Channel forwarding: only the granted master sees the slave, and only in the matching state
  always_comb begin
    m0_AWADDR  = '0;
    m0_AWVALID = 1'b0;
    m0_WDATA   = '0;
    m0_WSTRB   = '0;
    m0_WVALID  = 1'b0;
    m0_BREADY  = 1'b0;
    m0_ARADDR  = '0;
    m0_ARVALID = 1'b0;
    m0_RREADY  = 1'b0;
    s0_AWREADY = 1'b0;
    s0_WREADY  = 1'b0;
    s0_BRESP   = 2'b00;
    s0_BVALID  = 1'b0;
    s0_ARREADY = 1'b0;
    s0_RDATA   = '0;
    s0_RRESP   = 2'b00;
    s0_RVALID  = 1'b0;
    s1_AWREADY = 1'b0;
    s1_WREADY  = 1'b0;
    s1_BRESP   = 2'b00;
    s1_BVALID  = 1'b0;
    s1_ARREADY = 1'b0;
    s1_RDATA   = '0;
    s1_RRESP   = 2'b00;
    s1_RVALID  = 1'b0;
    aw_rdy     = 1'b0;
    w_rdy      = 1'b0;
    case (state)
      WR_ADDR: begin
        m0_AWADDR  = sel ? s1_AWADDR : s0_AWADDR;
        m0_AWVALID = (sel ? s1_AWVALID : s0_AWVALID) & ~aw_done;
        m0_WDATA   = sel ? s1_WDATA : s0_WDATA;
        m0_WSTRB   = sel ? s1_WSTRB : s0_WSTRB;
        m0_WVALID  = (sel ? s1_WVALID : s0_WVALID) & ~w_done;
        aw_rdy     = m0_AWREADY & ~aw_done;
        w_rdy      = m0_WREADY & ~w_done;
        s0_AWREADY = ~sel & aw_rdy;
        s1_AWREADY = sel & aw_rdy;
        s0_WREADY  = ~sel & w_rdy;
        s1_WREADY  = sel & w_rdy;
      end
      WR_RESP: begin
        m0_BREADY = sel ? s1_BREADY : s0_BREADY;
        s0_BVALID = ~sel & m0_BVALID;
        s1_BVALID = sel & m0_BVALID;
        s0_BRESP  = sel ? 2'b00 : m0_BRESP;
        s1_BRESP  = sel ? m0_BRESP : 2'b00;
      end
      RD_ADDR: begin
        m0_ARADDR  = sel ? s1_ARADDR : s0_ARADDR;
        m0_ARVALID = sel ? s1_ARVALID : s0_ARVALID;
        s0_ARREADY = ~sel & m0_ARREADY;
        s1_ARREADY = sel & m0_ARREADY;
      end
      RD_DATA: begin
        m0_RREADY = sel ? s1_RREADY : s0_RREADY;
        s0_RVALID = ~sel & m0_RVALID;
        s1_RVALID = sel & m0_RVALID;
        s0_RDATA  = sel ? '0 : m0_RDATA;
        s1_RDATA  = sel ? m0_RDATA : '0;
        s0_RRESP  = sel ? 2'b00 : m0_RRESP;
        s1_RRESP  = sel ? m0_RRESP : 2'b00;
      end
      default: ;
    endcase
  end

  // Next-state: arbitration in IDLE, then walk the granted transaction to completion
  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    last_nxt    = last;
    aw_done_nxt = aw_done;
    w_done_nxt  = w_done;
    req0        = s0_AWVALID | s0_ARVALID;
    req1        = s1_AWVALID | s1_ARVALID;
    pick1       = req1 & (~req0 | ~last);
    aw_hs       = m0_AWVALID & m0_AWREADY;
    w_hs        = m0_WVALID & m0_WREADY;
    case (state)
      IDLE: begin
        if (req0 | req1) begin
          gnt_nxt   = pick1 ? 2'b10 : 2'b01;
          state_nxt = (pick1 ? s1_AWVALID : s0_AWVALID) ? WR_ADDR : RD_ADDR;
        end
      end
      WR_ADDR: begin
        if ((aw_done | aw_hs) & (w_done | w_hs)) begin
          state_nxt   = WR_RESP;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
        end else begin
          aw_done_nxt = aw_done | aw_hs;
          w_done_nxt  = w_done | w_hs;
        end
      end
      WR_RESP: begin
        if (m0_BVALID & m0_BREADY) begin
          state_nxt = IDLE;
          gnt_nxt   = 2'b00;
          last_nxt  = sel;
        end
      end
      RD_ADDR: begin
        if (m0_ARVALID & m0_ARREADY) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        if (m0_RVALID & m0_RREADY) begin
          state_nxt = IDLE;
          gnt_nxt   = 2'b00;
          last_nxt  = sel;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 2'b00;
      end
    endcase
  end

endmodule

// File: tb/tb_axil_rr_arbiter_2m.sv
// Directed bench for axil_rr_arbiter_2m: the bench plays both masters and the slave
// cycle by cycle and compares against hand-computed values.
module tb_axil_rr_arbiter_2m;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_awaddr [2];
  logic        s_awvalid[2];
  logic [31:0] s_wdata  [2];
  logic [3:0]  s_wstrb  [2];
  logic        s_wvalid [2];
  logic        s_bready [2];
  logic [31:0] s_araddr [2];
  logic        s_arvalid[2];
  logic        s_rready [2];

  logic        m0_AWREADY, m0_WREADY, m0_BVALID, m0_ARREADY, m0_RVALID;
  logic [1:0]  m0_BRESP, m0_RRESP;
  logic [31:0] m0_RDATA;

  wire         s0_AWREADY, s0_WREADY, s0_BVALID, s0_ARREADY, s0_RVALID;
  wire [1:0]   s0_BRESP, s0_RRESP;
  wire [31:0]  s0_RDATA;
  wire         s1_AWREADY, s1_WREADY, s1_BVALID, s1_ARREADY, s1_RVALID;
  wire [1:0]   s1_BRESP, s1_RRESP;
  wire [31:0]  s1_RDATA;
  wire [31:0]  m0_AWADDR, m0_WDATA, m0_ARADDR;
  wire [3:0]   m0_WSTRB;
  wire         m0_AWVALID, m0_WVALID, m0_BREADY, m0_ARVALID, m0_RREADY;
  wire [1:0]   gnt;
  wire         busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axil_rr_arbiter_2m #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .s0_AWADDR(s_awaddr[0]), .s0_AWVALID(s_awvalid[0]), .s0_AWREADY(s0_AWREADY),
    .s0_WDATA(s_wdata[0]), .s0_WSTRB(s_wstrb[0]), .s0_WVALID(s_wvalid[0]), .s0_WREADY(s0_WREADY),
    .s0_BRESP(s0_BRESP), .s0_BVALID(s0_BVALID), .s0_BREADY(s_bready[0]),
    .s0_ARADDR(s_araddr[0]), .s0_ARVALID(s_arvalid[0]), .s0_ARREADY(s0_ARREADY),
    .s0_RDATA(s0_RDATA), .s0_RRESP(s0_RRESP), .s0_RVALID(s0_RVALID), .s0_RREADY(s_rready[0]),
    .s1_AWADDR(s_awaddr[1]), .s1_AWVALID(s_awvalid[1]), .s1_AWREADY(s1_AWREADY),
    .s1_WDATA(s_wdata[1]), .s1_WSTRB(s_wstrb[1]), .s1_WVALID(s_wvalid[1]), .s1_WREADY(s1_WREADY),
    .s1_BRESP(s1_BRESP), .s1_BVALID(s1_BVALID), .s1_BREADY(s_bready[1]),
    .s1_ARADDR(s_araddr[1]), .s1_ARVALID(s_arvalid[1]), .s1_ARREADY(s1_ARREADY),
    .s1_RDATA(s1_RDATA), .s1_RRESP(s1_RRESP), .s1_RVALID(s1_RVALID), .s1_RREADY(s_rready[1]),
    .m0_AWADDR(m0_AWADDR), .m0_AWVALID(m0_AWVALID), .m0_AWREADY(m0_AWREADY),
    .m0_WDATA(m0_WDATA), .m0_WSTRB(m0_WSTRB), .m0_WVALID(m0_WVALID), .m0_WREADY(m0_WREADY),
    .m0_BRESP(m0_BRESP), .m0_BVALID(m0_BVALID), .m0_BREADY(m0_BREADY),
    .m0_ARADDR(m0_ARADDR), .m0_ARVALID(m0_ARVALID), .m0_ARREADY(m0_ARREADY),
    .m0_RDATA(m0_RDATA), .m0_RRESP(m0_RRESP), .m0_RVALID(m0_RVALID), .m0_RREADY(m0_RREADY),
    .gnt(gnt), .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 2; i++) begin
      s_awaddr[i] = '0; s_awvalid[i] = 1'b0; s_wdata[i] = '0; s_wstrb[i] = '0;
      s_wvalid[i] = 1'b0; s_bready[i] = 1'b0; s_araddr[i] = '0; s_arvalid[i] = 1'b0;
      s_rready[i] = 1'b0;
    end
    m0_AWREADY = 1'b0; m0_WREADY = 1'b0; m0_BVALID = 1'b0; m0_BRESP = 2'b00;
    m0_ARREADY = 1'b0; m0_RVALID = 1'b0; m0_RDATA = '0; m0_RRESP = 2'b00;
  endtask

  // Every handshake-side output packed together; all must be 0 in IDLE/reset
  function automatic logic [63:0] ctl_vec();
    return 64'({m0_AWVALID, m0_WVALID, m0_ARVALID, m0_BREADY, m0_RREADY,
                s0_AWREADY, s0_WREADY, s0_BVALID, s0_ARREADY, s0_RVALID,
                s1_AWREADY, s1_WREADY, s1_BVALID, s1_ARREADY, s1_RVALID});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    rst = 1'b1;
    clear_inputs();
    repeat (3) @(negedge clk);
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ctl", ctl_vec(), 64'd0);
    check("rst_payload", 64'(m0_AWADDR | m0_ARADDR | m0_WDATA | 32'(m0_WSTRB)), 64'd0);
    rst = 1'b0;

    // T1: single s0 read
    @(negedge clk);
    s_araddr[0] = 32'h0000_0010; s_arvalid[0] = 1'b1;
    #1 check("t1_arvalid_same_cycle", 64'(m0_ARVALID), 64'd0);
    @(negedge clk);
    check("t1_arvalid", 64'(m0_ARVALID), 64'd1);
    check("t1_araddr", 64'(m0_ARADDR), 64'h10);
    check("t1_gnt", 64'(gnt), 64'd1);
    check("t1_busy", 64'(busy), 64'd1);
    m0_ARREADY = 1'b1;
    #1 check("t1_arready", 64'({s1_ARREADY, s0_ARREADY}), 64'b01);
    @(negedge clk);
    s_arvalid[0] = 1'b0; m0_ARREADY = 1'b0;
    m0_RDATA = 32'hDEAD_BEEF; m0_RRESP = 2'b00; m0_RVALID = 1'b1;
    s_rready[0] = 1'b1; s_rready[1] = 1'b1;
    #1 check("t1_rvalid", 64'({s1_RVALID, s0_RVALID}), 64'b01);
    check("t1_rdata", 64'(s0_RDATA), 64'hDEAD_BEEF);
    check("t1_rready", 64'(m0_RREADY), 64'd1);
    @(negedge clk);
    m0_RVALID = 1'b0;
    check("t1_idle_busy", 64'(busy), 64'd0);
    check("t1_idle_gnt", 64'(gnt), 64'd0);

    // T2: both masters read continuously after reset; grants must alternate starting with s0
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    s_araddr[0] = 32'h200; s_araddr[1] = 32'h300;
    s_arvalid[0] = 1'b1; s_arvalid[1] = 1'b1;
    m0_ARREADY = 1'b1; m0_RVALID = 1'b1; m0_RDATA = 32'h55;
    for (int k = 0; k < 8; k++) begin
      found = 1'b0;
      for (int t = 0; t < 8; t++) begin
        @(negedge clk);
        if (m0_ARVALID) begin
          found = 1'b1;
          break;
        end
      end
      check("t2_ar_seen", 64'(found), 64'd1);
      if (found) begin
        check("t2_gnt", 64'(gnt), (k % 2 == 1) ? 64'b10 : 64'b01);
        check("t2_araddr", 64'(m0_ARADDR), (k % 2 == 1) ? 64'h300 : 64'h200);
        @(negedge clk);
        check("t2_rvalid", 64'({s1_RVALID, s0_RVALID}), (k % 2 == 1) ? 64'b10 : 64'b01);
      end
    end
    @(negedge clk);
    s_arvalid[0] = 1'b0; s_arvalid[1] = 1'b0; m0_ARREADY = 1'b0; m0_RVALID = 1'b0;
    check("t2_idle_busy", 64'(busy), 64'd0);

    // T3: s1 write, W presented two cycles before AW, AW accepted before W
    m0_AWREADY = 1'b1; m0_WREADY = 1'b0;
    s_wdata[1] = 32'h1234_5678; s_wstrb[1] = 4'hF; s_wvalid[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t3_w_not_forwarded", 64'(m0_WVALID), 64'd0);
    s_awaddr[1] = 32'h100; s_awvalid[1] = 1'b1;
    @(negedge clk);
    check("t3_gnt", 64'(gnt), 64'b10);
    check("t3_awvalid", 64'(m0_AWVALID), 64'd1);
    check("t3_awaddr", 64'(m0_AWADDR), 64'h100);
    check("t3_wvalid", 64'(m0_WVALID), 64'd1);
    check("t3_wdata", 64'(m0_WDATA), 64'h1234_5678);
    check("t3_wstrb", 64'(m0_WSTRB), 64'hF);
    check("t3_readies", 64'({s1_AWREADY, s1_WREADY, s0_AWREADY, s0_WREADY}), 64'b1000);
    @(negedge clk);
    s_awvalid[1] = 1'b0;
    #1 check("t3_aw_done_ready", 64'(s1_AWREADY), 64'd0);
    check("t3_w_pending", 64'(m0_WVALID), 64'd1);
    m0_WREADY = 1'b1;
    #1 check("t3_wready", 64'(s1_WREADY), 64'd1);
    @(negedge clk);
    s_wvalid[1] = 1'b0; m0_AWREADY = 1'b0; m0_WREADY = 1'b0;
    m0_BRESP = 2'b00; m0_BVALID = 1'b1; s_bready[1] = 1'b1;
    #1 check("t3_bvalid", 64'({s1_BVALID, s0_BVALID}), 64'b10);
    check("t3_bresp", 64'(s1_BRESP), 64'd0);
    check("t3_bready", 64'(m0_BREADY), 64'd1);
    @(negedge clk);
    m0_BVALID = 1'b0;
    check("t3_idle_busy", 64'(busy), 64'd0);
    check("t3_idle_gnt", 64'(gnt), 64'd0);

    // T4: s0 raises AW, W and AR together; the write goes first, AW/W in one cycle
    m0_AWREADY = 1'b1; m0_WREADY = 1'b1;
    s_awaddr[0] = 32'h40; s_wdata[0] = 32'hA5A5_A5A5; s_wstrb[0] = 4'h3; s_araddr[0] = 32'h80;
    s_awvalid[0] = 1'b1; s_wvalid[0] = 1'b1; s_arvalid[0] = 1'b1;
    @(negedge clk);
    check("t4_gnt", 64'(gnt), 64'b01);
    check("t4_valids", 64'({m0_AWVALID, m0_WVALID, m0_ARVALID}), 64'b110);
    check("t4_wstrb", 64'(m0_WSTRB), 64'h3);
    @(negedge clk);
    s_awvalid[0] = 1'b0; s_wvalid[0] = 1'b0; m0_AWREADY = 1'b0; m0_WREADY = 1'b0;
    m0_BRESP = 2'b10; m0_BVALID = 1'b1; s_bready[0] = 1'b1;
    #1 check("t4_bvalid", 64'({s1_BVALID, s0_BVALID}), 64'b01);
    check("t4_bresp", 64'(s0_BRESP), 64'b10);
    check("t4_no_ar_yet", 64'(m0_ARVALID), 64'd0);
    @(negedge clk);
    m0_BVALID = 1'b0; m0_ARREADY = 1'b0;
    check("t4_idle_between", 64'({busy, m0_ARVALID}), 64'd0);

    // T5: slave stalls AR for 5 cycles
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_arvalid_hold", 64'(m0_ARVALID), 64'd1);
      check("t5_araddr_hold", 64'(m0_ARADDR), 64'h80);
      check("t5_arready_low", 64'(s0_ARREADY), 64'd0);
    end
    m0_ARREADY = 1'b1;
    @(negedge clk);
    s_arvalid[0] = 1'b0; m0_ARREADY = 1'b0;
    m0_RVALID = 1'b1; m0_RDATA = 32'hCAFE_F00D; m0_RRESP = 2'b10;
    #1 check("t5_rdata", 64'(s0_RDATA), 64'hCAFE_F00D);
    check("t5_rresp", 64'(s0_RRESP), 64'b10);
    @(negedge clk);
    m0_RVALID = 1'b0;

    // T6: reset while in RD_DATA, then a fresh read
    s_araddr[1] = 32'h30; s_arvalid[1] = 1'b1; m0_ARREADY = 1'b1;
    @(negedge clk);
    check("t6_gnt", 64'(gnt), 64'b10);
    @(negedge clk);
    s_arvalid[1] = 1'b0; m0_ARREADY = 1'b0;
    #1 check("t6_in_rd_data", 64'(m0_RREADY), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_gnt", 64'(gnt), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_ctl", ctl_vec(), 64'd0);
    rst = 1'b0;
    s_araddr[1] = 32'h34; s_arvalid[1] = 1'b1; m0_ARREADY = 1'b1;
    @(negedge clk);
    check("t6_fresh_gnt", 64'(gnt), 64'b10);
    check("t6_fresh_araddr", 64'(m0_ARADDR), 64'h34);
    @(negedge clk);
    s_arvalid[1] = 1'b0; m0_ARREADY = 1'b0;
    m0_RVALID = 1'b1; m0_RDATA = 32'h0BAD_F00D; m0_RRESP = 2'b00;
    #1 check("t6_rvalid", 64'({s1_RVALID, s0_RVALID}), 64'b10);
    check("t6_rdata", 64'(s1_RDATA), 64'h0BAD_F00D);
    @(negedge clk);
    m0_RVALID = 1'b0;
    check("t6_idle_busy", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
